// File: rtl/conv_output_requantizer_if.sv
// Pixel-valid strobe and kernel sums in, requantized 8-bit pixel vector with frame coordinates out.
// The master drives the convolution side; the slave is the requantizer.
interface conv_output_requantizer_if #(
  parameter int NUM_TREES = 4,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
);
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic                      pixel_valid_in;
  logic [32*NUM_TREES-1:0]   sum_vector_in;
  logic [4:0]                shift;
  logic                      relu_en;
  logic                      pixel_valid_out;
  logic [8*NUM_TREES-1:0]    pixel_vector_out;
  logic [RW-1:0]             row_out;
  logic [CW-1:0]             col_out;
  logic                      frame_done;

  modport master (
    output pixel_valid_in, sum_vector_in, shift, relu_en,
    input  pixel_valid_out, pixel_vector_out, row_out, col_out, frame_done
  );

  modport slave (
    input  pixel_valid_in, sum_vector_in, shift, relu_en,
    output pixel_valid_out, pixel_vector_out, row_out, col_out, frame_done
  );
endinterface

// File: rtl/conv_output_requantizer.sv
// Aligns pixel strobes to convolution sums, drops partial windows, then ReLU / round-shift / saturate.
// Latency CONV_LATENCY+1 cycles from pixel_valid_in; no backpressure, one result per kept beat.
module conv_output_requantizer #(
  parameter int NUM_TREES    = 4,
  parameter int IMG_W        = 28,
  parameter int IMG_H        = 28,
  parameter int KERNEL_SIZE  = 3,
  parameter int CONV_LATENCY = 6
) (
  input logic                        clock,
  input logic                        reset,
  conv_output_requantizer_if.slave   bus
);
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [CONV_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [CONV_LATENCY:0]   vld_tap;
  logic                    d_valid;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic                    last_row, last_col, keep;

  logic                    vld_out_q;
  logic [8*NUM_TREES-1:0]  vec_q, vec_d;
  logic [RW-1:0]           row_out_q;
  logic [CW-1:0]           col_out_q;
  logic                    done_q;

  // Tap 0 is the live input so a latency of 1 still yields a legal slice.
  assign vld_tap    = {vld_pipe_q, bus.pixel_valid_in};
  assign vld_pipe_d = vld_tap[CONV_LATENCY-1:0];
  assign d_valid    = vld_tap[CONV_LATENCY];

  assign last_row = (row_q == RW'(IMG_H - 1));
  assign last_col = (col_q == CW'(IMG_W - 1));
  assign keep     = d_valid && (row_q >= RW'(KERNEL_SIZE - 1)) && (col_q >= CW'(KERNEL_SIZE - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (d_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // 33 bits holds the largest positive sum plus the rounding bias without wrapping.
  function automatic logic [7:0] requant(input logic [31:0] s, input logic [4:0] sh, input logic relu);
    logic signed [32:0] x;
    logic signed [32:0] rnd;
    x = $signed({s[31], s});
    if (relu && s[31]) x = '0;
    if (sh != 5'd0) begin
      rnd = 33'sd1 <<< (sh - 5'd1);
      x   = (x + rnd) >>> sh;
    end
    if (x > 33'sd127)       return 8'h7F;
    else if (x < -33'sd128) return 8'h80;
    else                    return x[7:0];
  endfunction

  always_comb begin
    vec_d = '0;
    for (int k = 0; k < NUM_TREES; k++) begin
      vec_d[8*k +: 8] = requant(bus.sum_vector_in[32*k +: 32], bus.shift, bus.relu_en);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      vld_out_q  <= 1'b0;
      vec_q      <= '0;
      row_out_q  <= '0;
      col_out_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      row_q      <= row_d;
      col_q      <= col_d;
      vld_out_q  <= keep;
      done_q     <= keep && last_row && last_col;
      if (keep) begin
        vec_q     <= vec_d;
        row_out_q <= row_q - RW'(KERNEL_SIZE - 1);
        col_out_q <= col_q - CW'(KERNEL_SIZE - 1);
      end
    end
  end

  assign bus.pixel_valid_out  = vld_out_q;
  assign bus.pixel_vector_out = vec_q;
  assign bus.row_out          = row_out_q;
  assign bus.col_out          = col_out_q;
  assign bus.frame_done       = done_q;
endmodule

// File: tb/tb_conv_output_requantizer.sv
// Scoreboard bench: stimulus pushes expected beats with their due cycle; a negedge monitor pops and compares.
module tb_conv_output_requantizer;
  localparam int NT = 4;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int K  = 3;
  localparam int L  = 6;

  typedef struct {
    int          stamp;
    logic [31:0] vec;
    logic [4:0]  row;
    logic [4:0]  col;
    logic        done;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [127:0] sum_sched [64];

  logic signed [31:0] ar_in  [6] = '{32'sd40, 32'sd24, -32'sd24, 32'sd5000, -32'sd70000, 32'h7FFFFFFF};
  logic [7:0]         ar_exp [6] = '{8'd3, 8'd2, 8'hFF, 8'd127, 8'h80, 8'd127};
  logic signed [31:0] rl_in  [4] = '{-32'sd5, 32'sd0, 32'sd300, 32'sd99};
  logic [7:0]         rl_exp [4] = '{8'd0, 8'd0, 8'd127, 8'd99};

  conv_output_requantizer_if #(.NUM_TREES(NT), .IMG_W(W), .IMG_H(H)) bus ();

  conv_output_requantizer #(
    .NUM_TREES(NT), .IMG_W(W), .IMG_H(H), .KERNEL_SIZE(K), .CONV_LATENCY(L)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Sums reach the DUT L cycles after their strobe; unscheduled cycles carry noise.
  always @(posedge clock) begin
    #1;
    bus.sum_vector_in = sum_sched[cyc % 64];
    sum_sched[cyc % 64] = {$urandom, $urandom, $urandom, $urandom};
  end

  always @(negedge clock) begin
    if (bus.pixel_valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(bus.pixel_valid_out), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency",   64'(cyc), 64'(e.stamp));
        chk("vector",    64'(bus.pixel_vector_out), 64'(e.vec));
        chk("row",       64'(bus.row_out), 64'(e.row));
        chk("col",       64'(bus.col_out), 64'(e.col));
        chk("frame_done", 64'(bus.frame_done), 64'(e.done));
      end
    end else if (bus.frame_done) begin
      chk("done_without_valid", 64'(bus.frame_done), 64'd0);
    end
  end

  task automatic step(input logic v, input logic [127:0] sums, input logic push, input exp_t e);
    exp_t t;
    @(posedge clock);
    #1;
    bus.pixel_valid_in = v;
    if (v) sum_sched[(cyc + L) % 64] = sums;
    if (push) begin
      t = e;
      t.stamp = cyc + L + 1;
      exp_q.push_back(t);
    end
  endtask

  task automatic idle(input int n);
    exp_t e;
    e = '{0, 32'd0, 5'd0, 5'd0, 1'b0};
    for (int i = 0; i < n; i++) step(1'b0, 128'd0, 1'b0, e);
  endtask

  // mode 0: shift=0 identity pattern, 1: shift=4 arithmetic table, 2: ReLU table
  task automatic send_frame(input int mode, input bit gaps, input int npix);
    exp_t         e, blank;
    logic [127:0] sums;
    int           r, c, v, j, kj;
    logic         keep;
    blank = '{0, 32'd0, 5'd0, 5'd0, 1'b0};
    kj = 0;
    for (int idx = 0; idx < npix; idx++) begin
      if (gaps) idle($urandom_range(0, 3));
      r = idx / W;
      c = idx % W;
      keep = (r >= K - 1) && (c >= K - 1);
      e = blank;
      sums = {$urandom, $urandom, $urandom, $urandom};
      if (keep) begin
        for (int k = 0; k < NT; k++) begin
          if (mode == 0) begin
            v = (idx * 4 + k) % 128 - 64;
            sums[32*k +: 32] = 32'(v);
            e.vec[8*k +: 8]  = 8'(v);
          end else if (mode == 1) begin
            j = (kj + k) % 6;
            sums[32*k +: 32] = ar_in[j];
            e.vec[8*k +: 8]  = ar_exp[j];
          end else begin
            j = (kj + k) % 4;
            sums[32*k +: 32] = rl_in[j];
            e.vec[8*k +: 8]  = rl_exp[j];
          end
        end
        e.row  = 5'(r - (K - 1));
        e.col  = 5'(c - (K - 1));
        e.done = (r == H - 1) && (c == W - 1);
        kj++;
      end
      step(1'b1, sums, keep, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sum_sched[i] = {$urandom, $urandom, $urandom, $urandom};
    reset = 1'b1;
    bus.pixel_valid_in = 1'b1;
    bus.sum_vector_in  = '0;
    bus.shift          = 5'd0;
    bus.relu_en        = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk("reset_outputs",
          64'({bus.pixel_valid_out, bus.pixel_vector_out, bus.row_out, bus.col_out, bus.frame_done}),
          64'd0);
    end
    reset = 1'b0;
    bus.pixel_valid_in = 1'b0;

    send_frame(0, 1'b0, W * H);
    send_frame(0, 1'b0, W * H);
    idle(12);

    bus.shift = 5'd4;
    send_frame(1, 1'b0, W * H);
    idle(12);

    bus.shift   = 5'd0;
    bus.relu_en = 1'b1;
    send_frame(2, 1'b0, W * H);
    idle(12);

    bus.relu_en = 1'b0;
    send_frame(0, 1'b1, W * H);
    idle(12);

    send_frame(0, 1'b0, 400);
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.pixel_valid_in = 1'b0;
    @(posedge clock);
    #1;
    exp_q.delete();
    reset = 1'b0;
    idle(3);
    chk("no_output_after_reset", 64'(bus.pixel_valid_out), 64'd0);
    send_frame(0, 1'b0, W * H);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, pending %0d required 0", exp_q.size());
    $fatal(1, "watchdog");
  end
endmodule
